// File: rtl/dds_cmd_loader.sv
// Command loader for the DDS core: turns a 32-bit valid/ready word stream into parameter writes and wave-table loads.
// Optional feature macro: DDS_LOADER_CKSUM_EN (LOAD_WAVE frames carry a 32-bit sum trailer word).
`timescale 1ns/1ps
module dds_cmd_loader #(
    parameter int HORIZON_RESOLUTION  = 12,
    parameter int VERTICAL_RESOLUTION = 8,
    parameter int ADDER_LOWBIT        = 20,
    parameter int WAVE_STORE          = 2,
    localparam int ACC_W              = HORIZON_RESOLUTION + ADDER_LOWBIT,
    localparam int NCH                = 2 ** WAVE_STORE
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [31:0]                   s_data,
    input  logic                          s_last,
    output logic [WAVE_STORE-1:0]         wave_sel,
    output logic [ACC_W-1:0]              freq_ctrl  [0:NCH-1],
    output logic [HORIZON_RESOLUTION-1:0] phase_ctrl [0:NCH-1],
    output logic                          wr_enable,
    output logic                          wr_valid,
    output logic [31:0]                   wr_data,
    output logic                          busy,
    output logic                          err
);
    localparam int NSAMP = 2 ** HORIZON_RESOLUTION;
    localparam int CNT_W = HORIZON_RESOLUTION + 1;
    localparam logic [7:0] OP_SET_FREQ  = 8'h01;
    localparam logic [7:0] OP_SET_PHASE = 8'h02;
    localparam logic [7:0] OP_SELECT    = 8'h03;
    localparam logic [7:0] OP_LOAD_WAVE = 8'h04;

    generate
        if (VERTICAL_RESOLUTION > 32 || ACC_W > 32) begin : g_bad_width
            $error("samples and frequency words must fit in one 32-bit command word");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_PARAM, S_SELECT, S_PREP, S_LOAD, S_FIN, S_ERR
    } state_t;

    state_t                r_state, w_state_next;
    logic                  r_s_ready, w_ready_next;
    logic [7:0]            r_op, r_idx;
    logic                  r_hdr_last;
    logic                  r_drain_done, w_drain_done_next;
    logic                  r_prep_cnt, w_prep_cnt_next;
    logic [CNT_W-1:0]      r_cnt, w_cnt_next;
    logic [WAVE_STORE-1:0] r_home, w_home_next;
    logic [WAVE_STORE-1:0] r_wave_sel, w_wave_sel_next;
    logic                  r_wr_enable, r_wr_valid, r_busy, r_err;
    logic [31:0]           r_wr_data;
    logic                  w_accept, w_wr_accept, w_param_commit, w_err_next;
    logic                  w_idx_ok, w_in_idx_ok;
    logic [7:0]            w_in_idx;
`ifdef DDS_LOADER_CKSUM_EN
    logic [31:0]           r_sum, w_sum_next;
    logic                  r_sum_bad, w_sum_bad_next;
`endif

    assign w_accept    = s_valid && r_s_ready;
    assign w_in_idx    = s_data[23:16];
    assign w_in_idx_ok = ((w_in_idx >> WAVE_STORE) == 8'd0);
    assign w_idx_ok    = ((r_idx >> WAVE_STORE) == 8'd0);

    always_comb begin
        w_state_next      = r_state;
        w_drain_done_next = r_drain_done;
        w_prep_cnt_next   = r_prep_cnt;
        w_cnt_next        = r_cnt;
        w_home_next       = r_home;
        w_wr_accept       = 1'b0;
        w_param_commit    = 1'b0;
        w_err_next        = 1'b0;
`ifdef DDS_LOADER_CKSUM_EN
        w_sum_next        = r_sum;
        w_sum_bad_next    = r_sum_bad;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_HDR;
                    // A complete SELECT frame is a single word, so it commits as soon as it is accepted.
                    if (s_last && s_data[31:24] == OP_SELECT && w_in_idx_ok)
                        w_home_next = w_in_idx[WAVE_STORE-1:0];
                end
            end
            S_HDR: begin
                w_drain_done_next = r_hdr_last;
                w_prep_cnt_next   = 1'b0;
                w_cnt_next        = '0;
`ifdef DDS_LOADER_CKSUM_EN
                w_sum_next        = '0;
                w_sum_bad_next    = 1'b0;
`endif
                w_state_next      = S_ERR;
                if (w_idx_ok) begin
                    case (r_op)
                        OP_SET_FREQ, OP_SET_PHASE: if (!r_hdr_last) w_state_next = S_PARAM;
                        OP_SELECT:                 if (r_hdr_last)  w_state_next = S_SELECT;
                        OP_LOAD_WAVE:              if (!r_hdr_last) w_state_next = S_PREP;
                        default: ;
                    endcase
                end
            end
            S_PARAM: begin
                if (w_accept) begin
                    if (s_last) begin
                        w_param_commit = 1'b1;
                        w_state_next   = S_IDLE;
                    end else begin
                        w_state_next      = S_ERR;
                        w_drain_done_next = 1'b0;
                    end
                end
            end
            S_SELECT: w_state_next = S_IDLE;
            S_PREP: begin
                if (r_prep_cnt) w_state_next = S_LOAD;
                else            w_prep_cnt_next = 1'b1;
            end
            S_LOAD: begin
                if (w_accept) begin
`ifdef DDS_LOADER_CKSUM_EN
                    if (r_cnt != CNT_W'(NSAMP)) begin
                        w_wr_accept = 1'b1;
                        w_cnt_next  = r_cnt + CNT_W'(1);
                        w_sum_next  = r_sum + s_data;
                        if (s_last) begin
                            w_state_next      = S_ERR;
                            w_drain_done_next = 1'b1;
                        end
                    end else begin
                        // Trailer word: never written, only compared against the running sum.
                        w_sum_bad_next = (s_data != r_sum);
                        if (s_last) begin
                            w_state_next = S_FIN;
                        end else begin
                            w_state_next      = S_ERR;
                            w_drain_done_next = 1'b0;
                        end
                    end
`else
                    w_wr_accept = 1'b1;
                    w_cnt_next  = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(NSAMP - 1)) begin
                        w_state_next      = s_last ? S_FIN : S_ERR;
                        w_drain_done_next = 1'b0;
                    end else if (s_last) begin
                        w_state_next      = S_ERR;
                        w_drain_done_next = 1'b1;
                    end
`endif
                end
            end
            S_FIN: begin
                w_state_next = S_IDLE;
`ifdef DDS_LOADER_CKSUM_EN
                if (r_sum_bad) begin
                    w_state_next      = S_ERR;
                    w_drain_done_next = 1'b1;
                end
`endif
            end
            S_ERR: begin
                if (r_drain_done || (w_accept && s_last)) begin
                    w_state_next = S_IDLE;
                    w_err_next   = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ready_next = 1'b0;
        case (w_state_next)
            S_IDLE, S_PARAM, S_LOAD: w_ready_next = 1'b1;
            S_ERR:                   w_ready_next = !w_drain_done_next;
            default:                 w_ready_next = 1'b0;
        endcase
    end

    // The bank select stays on the target table until the cycle carrying the last write is over.
    always_comb begin
        w_wave_sel_next = w_home_next;
        if (w_state_next == S_PREP || w_state_next == S_LOAD || w_wr_accept)
            w_wave_sel_next = r_idx[WAVE_STORE-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_s_ready    <= 1'b0;
            r_op         <= '0;
            r_idx        <= '0;
            r_hdr_last   <= 1'b0;
            r_drain_done <= 1'b0;
            r_prep_cnt   <= 1'b0;
            r_cnt        <= '0;
            r_home       <= '0;
            r_wave_sel   <= '0;
            r_wr_enable  <= 1'b0;
            r_wr_valid   <= 1'b0;
            r_wr_data    <= '0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
`ifdef DDS_LOADER_CKSUM_EN
            r_sum        <= '0;
            r_sum_bad    <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_next;
            r_s_ready    <= w_ready_next;
            r_drain_done <= w_drain_done_next;
            r_prep_cnt   <= w_prep_cnt_next;
            r_cnt        <= w_cnt_next;
            r_home       <= w_home_next;
            r_wave_sel   <= w_wave_sel_next;
            r_wr_enable  <= (w_state_next == S_LOAD) || w_wr_accept;
            r_wr_valid   <= w_wr_accept;
            r_busy       <= (w_state_next != S_IDLE);
            r_err        <= w_err_next;
            if (w_wr_accept) r_wr_data <= s_data;
            if (r_state == S_IDLE && w_accept) begin
                r_op       <= s_data[31:24];
                r_idx      <= s_data[23:16];
                r_hdr_last <= s_last;
            end
`ifdef DDS_LOADER_CKSUM_EN
            r_sum        <= w_sum_next;
            r_sum_bad    <= w_sum_bad_next;
`endif
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [ACC_W-1:0]              r_freq;
            logic [HORIZON_RESOLUTION-1:0] r_phase;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_freq  <= '0;
                    r_phase <= '0;
                end else if (w_param_commit && r_idx[WAVE_STORE-1:0] == WAVE_STORE'(gi)) begin
                    if (r_op == OP_SET_FREQ) r_freq  <= s_data[ACC_W-1:0];
                    else                     r_phase <= s_data[HORIZON_RESOLUTION-1:0];
                end
            end
            assign freq_ctrl[gi]  = r_freq;
            assign phase_ctrl[gi] = r_phase;
        end
    endgenerate

    assign s_ready   = r_s_ready;
    assign wave_sel  = r_wave_sel;
    assign wr_enable = r_wr_enable;
    assign wr_valid  = r_wr_valid;
    assign wr_data   = r_wr_data;
    assign busy      = r_busy;
    assign err       = r_err;
endmodule

// File: tb/tb_dds_cmd_loader.sv
// Directed bench for dds_cmd_loader: table of single-frame commands plus hand-written load/error/reset sequences.
`timescale 1ns/1ps
module tb_dds_cmd_loader;
    localparam int NSAMP = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_ready;
    logic [1:0]  wave_sel;
    logic [31:0] freq_ctrl [0:3];
    logic [11:0] phase_ctrl [0:3];
    logic        wr_enable, wr_valid, busy, err;
    logic [31:0] wr_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dds_cmd_loader #(
        .HORIZON_RESOLUTION(12), .VERTICAL_RESOLUTION(8), .ADDER_LOWBIT(20), .WAVE_STORE(2)
    ) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .wave_sel(wave_sel), .freq_ctrl(freq_ctrl), .phase_ctrl(phase_ctrl),
        .wr_enable(wr_enable), .wr_valid(wr_valid), .wr_data(wr_data), .busy(busy), .err(err)
    );

    // Write-port monitor: counts writes, checks data order and bank, counts err pulses.
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    logic [1:0]  exp_bank = 2'd0;
    logic [1:0]  prev_sel = 2'd0;
    logic        prev_en = 1'b0;
    int wr_cnt = 0, wr_bad = 0, err_cnt = 0, sel_viol = 0;

    always @(negedge clk) begin
        if (err === 1'b1) err_cnt++;
        if (wr_valid === 1'b1) begin
            wr_cnt++;
            if (wr_enable !== 1'b1 || wave_sel !== exp_bank) wr_bad++;
            if (exp_q.size() == 0) wr_bad++;
            else begin
                mon_exp = exp_q.pop_front();
                if (wr_data !== mon_exp) wr_bad++;
            end
        end
        if (wr_enable === 1'b1 && prev_en === 1'b1 && wave_sel !== prev_sel) sel_viol++;
        prev_en  = wr_enable;
        prev_sel = wave_sel;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic l);
        int  n;
        logic acc;
        n = 0;
        acc = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!acc) begin
            @(negedge clk);
            acc = (s_ready === 1'b1);
            @(posedge clk);
            #1;
            n++;
            if (!acc && n > 20) begin
                n_checks++;
                n_errors++;
                $display("FAIL send_word: s_ready stayed %0b for word 0x%0h, required 1 within 20 cycles", s_ready, d);
                break;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [7:0] idx, input int n, input logic [31:0] pay);
        send_word({op, idx, 16'hA5C3}, n == 0);
        for (int k = 0; k < n; k++) send_word(pay, k == n - 1);
    endtask

    task automatic send_samples(input int n, input bit last_on_final, input bit rnd, output logic [31:0] sum);
        logic [31:0] d;
        sum = '0;
        for (int k = 0; k < n; k++) begin
            d = rnd ? $urandom : 32'(k % 256);
            exp_q.push_back(d);
            sum += d;
            send_word(d, last_on_final && (k == n - 1));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  idx;
        int          n;
        logic [31:0] pay;
        int          ch;
        logic [31:0] e_freq;
        logic [11:0] e_phase;
        logic [1:0]  e_sel;
        int          e_err;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] sum;
        int eb;
        bit ck;
`ifdef DDS_LOADER_CKSUM_EN
        ck = 1'b1;
`else
        ck = 1'b0;
`endif
        //           op     idx    n  payload        ch  freq           phase   sel err
        vecs[0]  = '{8'h01, 8'h01, 1, 32'h0010_0000, 1, 32'h0010_0000, 12'h000, 2'd0, 0};
        vecs[1]  = '{8'h02, 8'h02, 1, 32'hFFFF_F123, 2, 32'h0000_0000, 12'h123, 2'd0, 0};
        vecs[2]  = '{8'h01, 8'h03, 1, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 12'h000, 2'd0, 0};
        vecs[3]  = '{8'h03, 8'h02, 0, 32'h0000_0000, 0, 32'h0000_0000, 12'h000, 2'd2, 0};
        vecs[4]  = '{8'h01, 8'h04, 1, 32'h0000_1234, 0, 32'h0000_0000, 12'h000, 2'd2, 1};
        vecs[5]  = '{8'h01, 8'h00, 0, 32'h0000_0000, 0, 32'h0000_0000, 12'h000, 2'd2, 1};
        vecs[6]  = '{8'h02, 8'h01, 2, 32'h0000_0055, 1, 32'h0010_0000, 12'h000, 2'd2, 1};
        vecs[7]  = '{8'h7F, 8'h00, 2, 32'h0000_0099, 3, 32'hDEAD_BEEF, 12'h000, 2'd2, 1};
        vecs[8]  = '{8'h03, 8'h01, 1, 32'h0000_0000, 1, 32'h0010_0000, 12'h000, 2'd2, 1};
        vecs[9]  = '{8'h01, 8'h01, 1, 32'hAAAA_5555, 1, 32'hAAAA_5555, 12'h000, 2'd2, 0};
        vecs[10] = '{8'h03, 8'h40, 0, 32'h0000_0000, 2, 32'h0000_0000, 12'h123, 2'd2, 1};
        vecs[11] = '{8'h03, 8'h02, 0, 32'h0000_0000, 0, 32'h0000_0000, 12'h000, 2'd2, 0};

        // Reset state
        idle(3);
        $display("reset: checking reset values");
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_wave_sel", 32'(wave_sel), 32'd0);
        check("rst_wr_enable", 32'(wr_enable), 32'd0);
        check("rst_wr_valid", 32'(wr_valid), 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("rst_freq%0d", c), freq_ctrl[c], 32'd0);
            check($sformatf("rst_phase%0d", c), 32'(phase_ctrl[c]), 32'd0);
        end
        rst = 1'b0;
        idle(1);
        check("s_ready_after_rst", 32'(s_ready), 32'd1);

        // Table of single-frame commands, state carries over from row to row
        for (int i = 0; i < 12; i++) begin
            eb = err_cnt;
            send_frame(vecs[i].op, vecs[i].idx, vecs[i].n, vecs[i].pay);
            idle(4);
            $display("vec %0d: op 0x%02h idx 0x%02h words %0d", i, vecs[i].op, vecs[i].idx, vecs[i].n + 1);
            check($sformatf("v%0d_freq", i), freq_ctrl[vecs[i].ch], vecs[i].e_freq);
            check($sformatf("v%0d_phase", i), 32'(phase_ctrl[vecs[i].ch]), 32'(vecs[i].e_phase));
            check($sformatf("v%0d_wave_sel", i), 32'(wave_sel), 32'(vecs[i].e_sel));
            check($sformatf("v%0d_err_pulses", i), 32'(err_cnt - eb), 32'(vecs[i].e_err));
            check($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
        end

        // Parameter visible one cycle after the final word is accepted
        send_frame(8'h01, 8'h00, 1, 32'h0000_0077);
        $display("seq freq_timing: SET_FREQ idx 0 payload 0x77");
        check("freq_one_cycle", freq_ctrl[0], 32'h0000_0077);

        // Full table load to bank 3, home select 2
        exp_q.delete();
        wr_cnt = 0; wr_bad = 0; sel_viol = 0; exp_bank = 2'd3; eb = err_cnt;
        send_word({8'h04, 8'h03, 16'h0000}, 1'b0);
        idle(1);
        check("prep_wave_sel", 32'(wave_sel), 32'd3);
        check("prep_wr_enable", 32'(wr_enable), 32'd0);
        check("prep_s_ready", 32'(s_ready), 32'd0);
        check("prep_busy", 32'(busy), 32'd1);
        send_samples(NSAMP, !ck, 1'b0, sum);
        if (ck) send_word(sum, 1'b1);
        idle(4);
        $display("seq full_load: %0d writes observed", wr_cnt);
        check("load_wr_count", 32'(wr_cnt), 32'(NSAMP));
        check("load_wr_bad", 32'(wr_bad), 32'd0);
        check("load_sel_stable", 32'(sel_viol), 32'd0);
        check("load_home_restored", 32'(wave_sel), 32'd2);
        check("load_wr_enable_off", 32'(wr_enable), 32'd0);
        check("load_err", 32'(err_cnt - eb), 32'd0);
        check("load_busy", 32'(busy), 32'd0);

        // Short load: s_last on sample 100
        exp_q.delete();
        wr_cnt = 0; wr_bad = 0; exp_bank = 2'd1; eb = err_cnt;
        send_word({8'h04, 8'h01, 16'h0000}, 1'b0);
        send_samples(100, 1'b1, 1'b1, sum);
        idle(3);
        $display("seq short_load: %0d writes observed", wr_cnt);
        check("short_wr_count", 32'(wr_cnt), 32'd100);
        check("short_wr_bad", 32'(wr_bad), 32'd0);
        check("short_err", 32'(err_cnt - eb), 32'd1);
        check("short_wr_enable", 32'(wr_enable), 32'd0);
        check("short_busy", 32'(busy), 32'd0);
        check("short_home", 32'(wave_sel), 32'd2);

        // Reset in the middle of a load
        exp_q.delete();
        wr_cnt = 0; wr_bad = 0; exp_bank = 2'd0;
        send_word({8'h04, 8'h00, 16'h0000}, 1'b0);
        send_samples(2000, 1'b0, 1'b1, sum);
        rst = 1'b1;
        idle(1);
        $display("seq reset_mid_load: reset after %0d writes", wr_cnt);
        check("mid_rst_wr_count", 32'(wr_cnt), 32'd2000);
        check("mid_rst_wr_enable", 32'(wr_enable), 32'd0);
        check("mid_rst_wave_sel", 32'(wave_sel), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_s_ready", 32'(s_ready), 32'd0);
        for (int c = 0; c < 4; c++)
            check($sformatf("mid_rst_freq%0d", c), freq_ctrl[c], 32'd0);
        rst = 1'b0;
        idle(2);
        check("after_rst_s_ready", 32'(s_ready), 32'd1);

`ifdef DDS_LOADER_CKSUM_EN
        // Checksum trailer: correct, then off by one
        for (int t = 0; t < 2; t++) begin
            exp_q.delete();
            wr_cnt = 0; wr_bad = 0; exp_bank = 2'd1; eb = err_cnt;
            send_word({8'h04, 8'h01, 16'h0000}, 1'b0);
            send_samples(NSAMP, 1'b0, 1'b0, sum);
            send_word(sum + 32'(t), 1'b1);
            idle(5);
            $display("seq cksum trailer_delta %0d: %0d writes, %0d err pulses", t, wr_cnt, err_cnt - eb);
            check($sformatf("ck%0d_wr_count", t), 32'(wr_cnt), 32'(NSAMP));
            check($sformatf("ck%0d_wr_bad", t), 32'(wr_bad), 32'd0);
            check($sformatf("ck%0d_err", t), 32'(err_cnt - eb), 32'(t));
            check($sformatf("ck%0d_home", t), 32'(wave_sel), 32'd0);
            check($sformatf("ck%0d_busy", t), 32'(busy), 32'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/dds_cmd_loader.md
# dds_cmd_loader

Host-facing command loader placed directly upstream of the DDS core. Consumes a 32-bit valid/ready word stream and drives all DDS controls: waveform select, per-channel frequency and phase words, and the waveform-RAM write stream (`wr_enable`/`wr_valid`/`wr_data`). Loads wave tables so each table lands at its own RAM bank without host-visible address handling.

## Interface
- `HORIZON_RESOLUTION`, 12, address bits per wave table (table length 2**HORIZON_RESOLUTION)
- `VERTICAL_RESOLUTION`, 8, sample bits
- `ADDER_LOWBIT`, 20, accumulator fraction bits; ACC_W = HORIZON_RESOLUTION+ADDER_LOWBIT
- `WAVE_STORE`, 2, select bits (2**WAVE_STORE channels)

Ports:
- `clk` in 1, system clock
- `rst` in 1, reset, synchronous, active-high
- `s_valid` in 1, command word valid
- `s_ready` out 1, loader accepts word
- `s_data` in 32, command/payload word
- `s_last` in 1, last word of frame
- `wave_sel` out WAVE_STORE, to DDS wave_sel
- `freq_ctrl` out ACC_W, unpacked [0:2**WAVE_STORE-1], to DDS
- `phase_ctrl` out HORIZON_RESOLUTION, unpacked [0:2**WAVE_STORE-1], to DDS
- `wr_enable` out 1, `wr_valid` out 1, `wr_data` out 32, to DDS RAM write port
- `busy` out 1, high whenever state ≠ IDLE
- `err` out 1, one-cycle pulse per rejected frame

## Operation
- Word accepted when `s_valid && s_ready`. Frame = header word + payload; `s_last` marks final word.
- Header: [31:24] opcode, [23:16] index (bits above WAVE_STORE must be 0), [15:0] ignored.
- Opcodes: 0x01 SET_FREQ (1 payload word, `freq_ctrl[idx] <= payload[ACC_W-1:0]`); 0x02 SET_PHASE (1 payload, `phase_ctrl[idx] <= payload[HORIZON_RESOLUTION-1:0]`); 0x03 SELECT (no payload, `wave_sel <= idx`, becomes the "home" select); 0x04 LOAD_WAVE (exactly 2**HORIZON_RESOLUTION payload words).
- States: IDLE → HDR decode → {PARAM, SELECT, PREP, ERR}; PREP → LOAD → FIN → IDLE; PARAM/SELECT → IDLE; ERR → IDLE.
- LOAD_WAVE: PREP drives `wave_sel = idx`, `wr_enable = 0`, `s_ready = 0` for 2 cycles (lets DDS preload write address to bank start − 1). LOAD: `wr_enable = 1`; each accepted payload word gives `wr_valid = 1`, `wr_data = s_data` next cycle. 13-bit sample counter (HORIZON_RESOLUTION+1 bits). FIN: `wr_enable = 0`, `wave_sel` restored to home select, 1 cycle.
- Errors (→ ERR, drain with `s_ready = 1` until `s_last` accepted, then `err` pulse): unknown opcode; nonzero upper index bits; `s_last` on header of a payload opcode; `s_last` before final payload; missing `s_last` on final word. Parameter writes happen only on a well-formed frame (commit on `s_last`). Short LOAD_WAVE: samples already written stay; `wr_enable` drops, home select restored.
- Payload bits above the used width ignored (no error).

## Timing
- Reset values: `s_ready` 0 (goes 1 first cycle after `rst` deasserts), `wave_sel` 0, all `freq_ctrl`/`phase_ctrl` 0, `wr_enable` 0, `wr_valid` 0, `wr_data` 0, `busy` 0, `err` 0; home select 0.
- All outputs registered. Parameter update visible 1 cycle after accepting the final word.
- Write latency: payload accept at cycle N → `wr_valid`/`wr_data` at N+1. Back-to-back at 1 word/clk in LOAD.
- `s_ready` 0 in HDR, PREP, FIN; 1 in IDLE, PARAM, LOAD, ERR.
- `rst` mid-LOAD: next cycle all outputs at reset values; partial table stays in RAM.
- `wave_sel` never changes while `wr_enable = 1`.

## Configuration
- `DDS_LOADER_CKSUM_EN` defined: LOAD_WAVE carries one extra trailer word (with `s_last`) = 32-bit modular sum of the 2**HORIZON_RESOLUTION payload words; trailer not written to RAM; mismatch → `err` pulse after FIN (table already written). Without it: no trailer; word 2**HORIZON_RESOLUTION carries `s_last`.

## Test plan
- Reset, then SET_FREQ idx 1 payload 0x0010_0000 → `freq_ctrl[1]` = 0x0010_0000 one cycle after accept, others 0, `err` 0.
- SELECT idx 2 then LOAD_WAVE idx 3 with 4096 samples 0..255 repeating → `wave_sel` 3 for PREP+LOAD, exactly 4096 `wr_valid` pulses, `wr_data` matches, `wave_sel` back to 2 after FIN.
- Opcode 0x7F with 3 words → all 3 accepted, one `err` pulse, no outputs changed.
- LOAD_WAVE with `s_last` on sample 100 → 100 writes, `err` pulse, `wr_enable` 0, `busy` 0 within 3 cycles.
- `rst` asserted at sample 2000 of a load → next cycle `wr_enable` 0, `wave_sel` 0, `freq_ctrl` all 0.
- With `DDS_LOADER_CKSUM_EN`: correct trailer → no `err`; trailer +1 → one `err` pulse after FIN.
